layer_sequencer: RTL and testbench

Start/done-handshake sequencer for the CNN inference chain: conv1, relu1, maxpool1, conv2, relu2, maxpool2, flatten, dense. On `start` it launches each stage in order, waits for that stage's completion, and then moves to the next stage. It enforces a per-stage timeout and reports the total cycles spent. After dense completes it pulses `done`, which gates argmax and the predicted-digit capture. It replaces free-running enable generation with explicit per-stage handshakes.

---
 rtl/cnn_ctrl_pkg.sv | 28 ++
 rtl/stage_timer.sv | 31 +++
 rtl/layer_sequencer.sv | 140 ++++++++++++++
 tb/tb_layer_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN inference control path: sequencer states,
// stage indices and the default chain length.
package cnn_ctrl_pkg;

   localparam int NUM_STAGES_DEF = 8;

   localparam int STG_CONV1    = 0;
   localparam int STG_RELU1    = 1;
   localparam int STG_MAXPOOL1 = 2;
   localparam int STG_CONV2    = 3;
   localparam int STG_RELU2    = 4;
   localparam int STG_MAXPOOL2 = 5;
   localparam int STG_FLATTEN  = 6;
   localparam int STG_DENSE    = 7;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_LAUNCH = 3'd1;
   localparam state_t ST_WAIT   = 3'd2;
   localparam state_t ST_DONE   = 3'd3;
   localparam state_t ST_ERROR  = 3'd4;

   function automatic logic is_busy(input state_t s);
      return (s == ST_LAUNCH) || (s == ST_WAIT);
   endfunction

endpackage

// File: rtl/stage_timer.sv
// Per-stage watchdog: loaded to 1 on launch, counts while waiting, flags when
// it reaches the limit. A limit of 0 never flags.
module stage_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int          W              = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic inc,
   output logic expired
);

   logic [W-1:0] count_r;

   // saturating counter so a disabled timeout can never wrap back onto the limit
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= '0;
      end else if (load) begin
         count_r <= W'(1);
      end else if (inc && (count_r != {W{1'b1}})) begin
         count_r <= count_r + W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (TIMEOUT_CYCLES != 32'd0) && (count_r == W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/layer_sequencer.sv
// Start/done handshake sequencer for the CNN stage chain with per-stage
// timeout, abort, sticky error reporting and busy-cycle accounting.
module layer_sequencer
   import cnn_ctrl_pkg::*;
#(
   parameter int          NUM_STAGES     = NUM_STAGES_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int          CNT_WIDTH      = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          abort,
   input  logic [NUM_STAGES-1:0]         stage_done,
   output logic [NUM_STAGES-1:0]         stage_start,
   output logic [NUM_STAGES-1:0]         stage_enable,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [$clog2(NUM_STAGES)-1:0] err_stage,
   output logic [CNT_WIDTH-1:0]          cycle_count
);

   localparam int                   IDX_W    = $clog2(NUM_STAGES);
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_STAGES - 1);
   localparam logic [NUM_STAGES-1:0] ONE_HOT0 = NUM_STAGES'(1);

   state_t           state_r;
   state_t           state_next;
   logic [IDX_W-1:0] idx_r;
   logic [IDX_W-1:0] idx_next;
   logic             accept_start;
   logic             err_set;
   logic             timeout;

   // next-state logic; abort beats done, done beats timeout
   always_comb begin
      state_next   = state_r;
      idx_next     = idx_r;
      accept_start = 1'b0;
      err_set      = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_next   = ST_LAUNCH;
               idx_next     = '0;
               accept_start = 1'b1;
            end else if (state_r == ST_DONE) begin
               state_next = ST_IDLE;
            end else begin
               state_next = state_r;
            end
         end
         ST_LAUNCH, ST_WAIT: begin
            if (abort) begin
               state_next = ST_ERROR;
               err_set    = 1'b1;
            end else if (stage_done[idx_r]) begin
               if (idx_r == LAST_IDX) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_LAUNCH;
                  idx_next   = idx_r + IDX_W'(1);
               end
            end else if (timeout) begin
               state_next = ST_ERROR;
               err_set    = 1'b1;
            end else begin
               state_next = ST_WAIT;
            end
         end
         default: begin
            state_next = ST_IDLE;
            idx_next   = '0;
         end
      endcase
   end

   stage_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .W              (32)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (state_next == ST_LAUNCH),
      .inc     (state_next == ST_WAIT),
      .expired (timeout)
   );

   // state and handshake outputs are registered from the next-state decode
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         idx_r        <= '0;
         stage_start  <= '0;
         stage_enable <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_r      <= state_next;
         idx_r        <= idx_next;
         stage_start  <= (state_next == ST_LAUNCH) ? (ONE_HOT0 << idx_next) : '0;
         stage_enable <= is_busy(state_next) ? (ONE_HOT0 << idx_next) : '0;
         busy         <= is_busy(state_next);
         done         <= (state_next == ST_DONE);
      end
   end

   // sticky error status and the saturating busy-cycle counter
   always_ff @(posedge clk) begin
      if (rst) begin
         error       <= 1'b0;
         err_stage   <= '0;
         cycle_count <= '0;
      end else begin
         if (accept_start) begin
            error <= 1'b0;
         end else if (err_set) begin
            error <= 1'b1;
         end else begin
            error <= error;
         end

         if (err_set) begin
            err_stage <= idx_r;
         end else begin
            err_stage <= err_stage;
         end

         if (accept_start) begin
            cycle_count <= '0;
         end else if (busy && (cycle_count != {CNT_WIDTH{1'b1}})) begin
            cycle_count <= cycle_count + CNT_WIDTH'(1);
         end else begin
            cycle_count <= cycle_count;
         end
      end
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: one instance with the default timeout and
// one with a 4-cycle timeout, both driven from the same stimulus.
module tb_layer_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic [7:0] stage_done;

   logic [7:0]  a_start, a_en, b_start, b_en;
   logic        a_busy, a_done, a_error, b_busy, b_done, b_error;
   logic [2:0]  a_err_stage, b_err_stage;
   logic [31:0] a_count, b_count;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   int lat[8] = '{3, 1, 5, 1, 1, 4, 2, 10};
   int launch[8];

   always #5 clk = ~clk;

   layer_sequencer #(.NUM_STAGES(8), .TIMEOUT_CYCLES(65535), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .stage_done(stage_done),
      .stage_start(a_start), .stage_enable(a_en), .busy(a_busy), .done(a_done),
      .error(a_error), .err_stage(a_err_stage), .cycle_count(a_count)
   );

   layer_sequencer #(.NUM_STAGES(8), .TIMEOUT_CYCLES(4), .CNT_WIDTH(32)) dut_to (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .stage_done(stage_done),
      .stage_start(b_start), .stage_enable(b_en), .busy(b_busy), .done(b_done),
      .error(b_error), .err_stage(b_err_stage), .cycle_count(b_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      stage_done = 8'h00;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_start"}, 64'(a_start), 64'h0);
      check({tag, "_en"}, 64'(a_en), 64'h0);
      check({tag, "_busy"}, 64'(a_busy), 64'h0);
      check({tag, "_done"}, 64'(a_done), 64'h0);
      check({tag, "_error"}, 64'(a_error), 64'h0);
      check({tag, "_err_stage"}, 64'(a_err_stage), 64'h0);
      check({tag, "_count"}, 64'(a_count), 64'h0);
   endtask

   // every stage completes in its own launch cycle
   task automatic run_immediate(input string tag);
      logic [7:0] oh;
      cyc        = 0;
      stage_done = 8'hFF;
      start      = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         oh = 8'd1 << (c - 1);
         check({tag, "_walk_start"}, 64'(a_start), 64'(oh));
         check({tag, "_walk_en"}, 64'(a_en), 64'(oh));
         check({tag, "_walk_busy"}, 64'(a_busy), 64'h1);
         tick();
      end
      check({tag, "_done"}, 64'(a_done), 64'h1);
      check({tag, "_busy_low"}, 64'(a_busy), 64'h0);
      check({tag, "_count"}, 64'(a_count), 64'd8);
      check({tag, "_en_low"}, 64'(a_en), 64'h0);
      stage_done = 8'h00;
      tick();
      check({tag, "_done_pulse"}, 64'(a_done), 64'h0);
   endtask

   initial begin
      logic [7:0] oh;
      int k;

      @(negedge clk);
      do_reset();
      check_idle_outputs("reset");

      run_immediate("imm");

      // staged latencies with a stray done on the next stage and a start while busy
      launch[0] = 1;
      for (int j = 1; j < 8; j++) launch[j] = launch[j-1] + lat[j-1];
      cyc        = 0;
      stage_done = 8'h00;
      start      = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 28; c++) begin
         k = -1;
         for (int j = 0; j < 8; j++) begin
            if (c >= launch[j] && c < launch[j] + lat[j]) k = j;
         end
         if (k >= 0) begin
            oh = 8'd1 << k;
            check("lat_en", 64'(a_en), 64'(oh));
            check("lat_start", 64'(a_start), (c == launch[k]) ? 64'(oh) : 64'h0);
            check("lat_done_early", 64'(a_done), 64'h0);
            stage_done = ((c == launch[k] + lat[k] - 1) ? oh : 8'h00) | (8'd1 << ((k + 1) % 8));
         end else begin
            check("lat_done", 64'(a_done), 64'h1);
            check("lat_busy_low", 64'(a_busy), 64'h0);
            check("lat_count", 64'(a_count), 64'd27);
            stage_done = 8'h00;
         end
         start = (c == 7);
         tick();
      end
      check("lat_count_hold", 64'(a_count), 64'd27);
      check("lat_done_pulse", 64'(a_done), 64'h0);

      // 4-cycle timeout on stage 3 (second instance)
      do_reset();
      start = 1'b1;
      cyc   = 0;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         if (c <= 3) begin
            oh = 8'd1 << (c - 1);
            check("to_start", 64'(b_start), 64'(oh));
            stage_done = oh;
         end else begin
            check("to_wait_en", 64'(b_en), 64'h08);
            check("to_no_error", 64'(b_error), 64'h0);
            stage_done = 8'h00;
         end
         tick();
      end
      check("to_error", 64'(b_error), 64'h1);
      check("to_err_stage", 64'(b_err_stage), 64'd3);
      check("to_en_low", 64'(b_en), 64'h0);
      check("to_busy_low", 64'(b_busy), 64'h0);
      check("to_count", 64'(b_count), 64'd7);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("to_restart_error_clr", 64'(b_error), 64'h0);
      check("to_restart_start", 64'(b_start), 64'h01);
      check("to_restart_count", 64'(b_count), 64'd0);

      // abort in stage 5 together with its done
      do_reset();
      start = 1'b1;
      cyc   = 0;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (c <= 5) begin
            stage_done = 8'd1 << (c - 1);
         end else begin
            check("ab_wait_en", 64'(a_en), 64'h20);
            stage_done = (c == 8) ? 8'h20 : 8'h00;
            abort      = (c == 8);
         end
         tick();
      end
      abort      = 1'b0;
      stage_done = 8'h00;
      check("ab_error", 64'(a_error), 64'h1);
      check("ab_err_stage", 64'(a_err_stage), 64'd5);
      check("ab_en_low", 64'(a_en), 64'h0);
      check("ab_no_start6", 64'(a_start), 64'h0);
      check("ab_no_done", 64'(a_done), 64'h0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_still_no_start", 64'(a_start), 64'h0);
      check("ab_error_sticky", 64'(a_error), 64'h1);
      check("ab_count", 64'(a_count), 64'd8);

      // reset during stage 4, then a full rerun
      do_reset();
      start = 1'b1;
      cyc   = 0;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         stage_done = (c <= 4) ? (8'd1 << (c - 1)) : 8'h00;
         if (c == 5) begin
            check("rst_stage4_en", 64'(a_en), 64'h10);
            rst = 1'b1;
         end
         tick();
      end
      rst = 1'b0;
      check_idle_outputs("rst_mid");
      tick();
      run_immediate("rerun");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
